// File: rtl/ariane_pkg.sv
// Shared frontend/execute types plus the BOP return-address encoding used by
// both the branch unit (encode on call) and the return-address stack (decode).
package ariane_pkg;

   localparam int unsigned VLEN = 32;

   // XOR key applied to the low 31 bits of every link value written to ra.
   localparam logic [30:0] BOP_RA_KEY = 31'h73fa06c2;

   typedef enum logic [2:0] {
      NoCF,
      Branch,
      Jump,
      JumpR,
      Return
   } cf_t;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic [VLEN-1:0] target_address;
      logic            is_mispredict;
      logic            is_taken;
      cf_t             cf_type;
   } bp_resolve_t;

   // Bit VLEN-1 stays clear on encoded values so a raw address is detectable.
   function automatic logic [VLEN-1:0] bop_ra_encode(input logic [VLEN-1:0] pc);
      return {1'b0, pc[30:0] ^ BOP_RA_KEY};
   endfunction

   function automatic logic [VLEN-1:0] bop_ra_decode(input logic [VLEN-1:0] enc);
      return {1'b1, enc[30:0] ^ BOP_RA_KEY};
   endfunction

endpackage

// File: rtl/bop_ras_checker.sv
// Holds the last issued return prediction, compares it with the resolved
// Return target from execute and keeps the sticky crash request.
module bop_ras_checker
   import ariane_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            en_crash_i,
   input  logic            pop_fire_i,
   input  logic [VLEN-1:0] pop_addr_i,
   input  logic            tamper_i,
   input  bp_resolve_t     resolved_branch_i,
   output logic            mismatch_o,
   output logic            crash_o
);

   logic [VLEN-1:0] pend_q, pend_d;
   logic            pend_v_q, pend_v_d;
   logic            mismatch_q, mismatch_d;
   logic            crash_q, crash_d;
   logic            check_fire;
   logic            diverge;
   logic            unused_rb;

   assign unused_rb = ^{resolved_branch_i.pc, resolved_branch_i.is_mispredict,
                        resolved_branch_i.is_taken};

   assign check_fire = resolved_branch_i.valid && (resolved_branch_i.cf_type == Return) &&
                       pend_v_q;
   assign diverge    = check_fire && (resolved_branch_i.target_address != pend_q);

   always_comb begin
      pend_d     = pend_q;
      pend_v_d   = pend_v_q;
      mismatch_d = 1'b0;
      crash_d    = crash_q;
      if (flush_i) begin
         pend_v_d = 1'b0;
         crash_d  = 1'b0;
      end else begin
         if (check_fire) begin
            pend_v_d = 1'b0;
         end
         // A same-cycle pop reloads after the check has consumed the old value.
         if (pop_fire_i) begin
            pend_d   = pop_addr_i;
            pend_v_d = 1'b1;
         end
         mismatch_d = diverge;
         if (en_crash_i && (diverge || tamper_i)) begin
            crash_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_q     <= '0;
         pend_v_q   <= 1'b0;
         mismatch_q <= 1'b0;
         crash_q    <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_v_q   <= pend_v_d;
         mismatch_q <= mismatch_d;
         crash_q    <= crash_d;
      end
   end

   assign mismatch_o = mismatch_q;
   assign crash_o    = crash_q;

endmodule

// File: rtl/bop_ras.sv
// Circular return-address stack holding XOR-encoded link values; decodes the
// top entry into a return prediction and cross-checks it on resolve.
module bop_ras
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter logic [30:0] KEY   = BOP_RA_KEY
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            en_crash_i,
   input  logic            push_i,
   input  logic [VLEN-1:0] push_data_i,
   input  logic            pop_i,
   output logic            ras_valid_o,
   output logic [VLEN-1:0] ras_addr_o,
   input  bp_resolve_t     resolved_branch_i,
   output logic            overflow_o,
   output logic            tamper_o,
   output logic            mismatch_o,
   output logic            crash_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

   // Only the 31 key-encoded bits are stored; bit VLEN-1 is zero by construction.
   logic [30:0]     mem_q [DEPTH];
   logic [30:0]     mem_d [DEPTH];
   logic [PtrW-1:0] tp_q, tp_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            overflow_q, overflow_d;
   logic            tamper_q, tamper_d;

   logic            stack_empty;
   logic            stack_full;
   logic            push_ok;
   logic            tamper_evt;
   logic            pop_ok;
   logic [PtrW-1:0] tp_inc;
   logic [PtrW-1:0] tp_dec;

   assign stack_empty = (cnt_q == '0);
   assign stack_full  = (cnt_q == CntFull);
   assign tamper_evt  = push_i && push_data_i[VLEN-1];
   assign push_ok     = push_i && !push_data_i[VLEN-1];
   assign pop_ok      = pop_i && !stack_empty;
   assign tp_inc      = tp_q + PtrW'(1);
   assign tp_dec      = tp_q - PtrW'(1);

   assign ras_valid_o = !stack_empty;
   assign ras_addr_o  = {1'b1, mem_q[tp_q] ^ KEY};

   always_comb begin
      mem_d      = mem_q;
      tp_d       = tp_q;
      cnt_d      = cnt_q;
      overflow_d = 1'b0;
      tamper_d   = 1'b0;
      if (flush_i) begin
         tp_d  = '0;
         cnt_d = '0;
      end else begin
         tamper_d = tamper_evt;
         if (push_ok && pop_ok) begin
            // Call and return in one cycle: replace the top in place.
            mem_d[tp_q] = push_data_i[30:0];
         end else if (push_ok) begin
            mem_d[tp_inc] = push_data_i[30:0];
            tp_d          = tp_inc;
            if (stack_full) begin
               overflow_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end else if (pop_ok) begin
            tp_d  = tp_dec;
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tp_q       <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         tamper_q   <= 1'b0;
      end else begin
         tp_q       <= tp_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         tamper_q   <= tamper_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         mem_q <= mem_d;
      end
   end

   assign overflow_o = overflow_q;
   assign tamper_o   = tamper_q;

   bop_ras_checker u_checker (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .flush_i           (flush_i),
      .en_crash_i        (en_crash_i),
      .pop_fire_i        (pop_ok),
      .pop_addr_i        (ras_addr_o),
      .tamper_i          (tamper_evt),
      .resolved_branch_i (resolved_branch_i),
      .mismatch_o        (mismatch_o),
      .crash_o           (crash_o)
   );

endmodule

// File: tb/tb_bop_ras.sv
// Directed, table-driven bench for bop_ras with DEPTH=4 and the default key.
module tb_bop_ras;
   import ariane_pkg::*;

   logic        clk;
   logic        rst_ni;
   logic        flush;
   logic        en_crash;
   logic        push;
   logic [31:0] push_data;
   logic        pop;
   logic        ras_valid;
   logic [31:0] ras_addr;
   bp_resolve_t rb;
   logic        overflow;
   logic        tamper;
   logic        mismatch;
   logic        crash;

   int checks = 0;
   int errors = 0;

   bop_ras #(
      .DEPTH (4),
      .KEY   (31'h73fa06c2)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .flush_i           (flush),
      .en_crash_i        (en_crash),
      .push_i            (push),
      .push_data_i       (push_data),
      .pop_i             (pop),
      .ras_valid_o       (ras_valid),
      .ras_addr_o        (ras_addr),
      .resolved_branch_i (rb),
      .overflow_o        (overflow),
      .tamper_o          (tamper),
      .mismatch_o        (mismatch),
      .crash_o           (crash)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        push;
      logic [31:0] pd;
      logic        pop;
      logic        flush;
      logic        en;
      logic        rv;
      cf_t         ty;
      logic [31:0] tgt;
      logic        ev;
      logic        ca;
      logic [31:0] ea;
      logic        eo;
      logic        et;
      logic        em;
      logic        ec;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] enc(input logic [31:0] pc);
      logic [30:0] k;
      k = 31'h73fa06c2;
      return {1'b0, pc[30:0] ^ k};
   endfunction

   function automatic void add(input string name, input logic pu, input logic [31:0] pd,
                               input logic po, input logic fl, input logic en, input logic rv,
                               input cf_t ty, input logic [31:0] tgt, input logic ev,
                               input logic ca, input logic [31:0] ea, input logic eo,
                               input logic et, input logic em, input logic ec);
      vec_t v;
      v.name = name; v.push = pu; v.pd = pd; v.pop = po; v.flush = fl; v.en = en;
      v.rv = rv; v.ty = ty; v.tgt = tgt; v.ev = ev; v.ca = ca; v.ea = ea;
      v.eo = eo; v.et = et; v.em = em; v.ec = ec;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 1'b0; push_data = '0; pop = 1'b0; flush = 1'b0;
      rb = '0; rb.cf_type = NoCF;
   endtask

   task automatic chk_outs(input string tag, input logic ev, input logic eo, input logic et,
                           input logic em, input logic ec);
      chk({tag, ".valid"}, {31'd0, ras_valid}, {31'd0, ev});
      chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
      chk({tag, ".tamper"}, {31'd0, tamper}, {31'd0, et});
      chk({tag, ".mismatch"}, {31'd0, mismatch}, {31'd0, em});
      chk({tag, ".crash"}, {31'd0, crash}, {31'd0, ec});
   endtask

   initial begin
      idle();
      en_crash = 1'b0;
      rst_ni   = 1'b0;
      step();
      step();
      chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_ni = 1'b1;

      //   name       push pd                    pop fl en rv ty      tgt          ev ca ea          eo et em ec
      add("push1",    1, enc(32'h80000010), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000010, 0, 0, 0, 0);
      add("pop1",     0, 32'h0,             1, 0, 0, 0, NoCF,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
      add("res_ok",   0, 32'h0,             0, 0, 1, 1, Return, 32'h80000010, 0, 0, 32'h0,        0, 0, 0, 0);
      add("res_nopd", 0, 32'h0,             0, 0, 1, 1, Return, 32'h80000999, 0, 0, 32'h0,        0, 0, 0, 0);
      add("fill1",    1, enc(32'h80000100), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000100, 0, 0, 0, 0);
      add("fill2",    1, enc(32'h80000200), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000200, 0, 0, 0, 0);
      add("fill3",    1, enc(32'h80000300), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000300, 0, 0, 0, 0);
      add("fill4",    1, enc(32'h80000400), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000400, 0, 0, 0, 0);
      add("fill5_ov", 1, enc(32'h80000500), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000500, 1, 0, 0, 0);
      add("popA",     0, 32'h0,             1, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000400, 0, 0, 0, 0);
      add("popB",     0, 32'h0,             1, 0, 1, 1, Return, 32'h80000500, 1, 1, 32'h80000300, 0, 0, 0, 0);
      add("popC",     0, 32'h0,             1, 0, 1, 1, Return, 32'h80000400, 1, 1, 32'h80000200, 0, 0, 0, 0);
      add("popD",     0, 32'h0,             1, 0, 1, 1, Return, 32'h80000300, 0, 0, 32'h0,        0, 0, 0, 0);
      add("pop_empt", 0, 32'h0,             1, 0, 1, 1, Return, 32'h80000200, 0, 0, 32'h0,        0, 0, 0, 0);
      add("res_idle", 0, 32'h0,             0, 0, 1, 1, Return, 32'h80000200, 0, 0, 32'h0,        0, 0, 0, 0);
      add("pushB",    1, enc(32'h80000b00), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000b00, 0, 0, 0, 0);
      add("pp_repl",  1, enc(32'h80000a00), 1, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000a00, 0, 0, 0, 0);
      add("pp_cnt",   0, 32'h0,             1, 0, 1, 1, Return, 32'h80000b00, 0, 0, 32'h0,        0, 0, 0, 0);
      add("pp_pend",  0, 32'h0,             0, 0, 1, 1, Return, 32'h80000a00, 0, 0, 32'h0,        0, 0, 0, 0);
      add("pp_empty", 1, enc(32'h80000c00), 1, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000c00, 0, 0, 0, 0);
      add("pp_nopd",  0, 32'h0,             0, 0, 1, 1, Return, 32'h80000777, 1, 1, 32'h80000c00, 0, 0, 0, 0);
      add("push100",  1, enc(32'h80000100), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000100, 0, 0, 0, 0);
      add("pop100",   0, 32'h0,             1, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000c00, 0, 0, 0, 0);
      add("mis_en",   0, 32'h0,             0, 0, 1, 1, Return, 32'h80000104, 1, 1, 32'h80000c00, 0, 0, 1, 1);
      add("crash_hd", 0, 32'h0,             0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000c00, 0, 0, 0, 1);
      add("flush1",   0, 32'h0,             0, 1, 0, 0, NoCF,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
      add("push100b", 1, enc(32'h80000100), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000100, 0, 0, 0, 0);
      add("pop100b",  0, 32'h0,             1, 0, 0, 0, NoCF,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
      add("mis_dis",  0, 32'h0,             0, 0, 0, 1, Return, 32'h80000104, 0, 0, 32'h0,        0, 0, 1, 0);
      add("mis_end",  0, 32'h0,             0, 0, 0, 0, NoCF,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
      add("pushD",    1, enc(32'h80000d00), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000d00, 0, 0, 0, 0);
      add("tamp_en",  1, 32'h80001234,      0, 0, 1, 0, NoCF,   32'h0,        1, 1, 32'h80000d00, 0, 1, 0, 1);
      add("tamp_end", 0, 32'h0,             0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000d00, 0, 0, 0, 1);
      add("flush2",   0, 32'h0,             0, 1, 0, 0, NoCF,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
      add("pushE1",   1, enc(32'h80000e10), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000e10, 0, 0, 0, 0);
      add("pushE2",   1, enc(32'h80000e20), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000e20, 0, 0, 0, 0);
      add("pushE3",   1, enc(32'h80000e30), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000e30, 0, 0, 0, 0);
      add("fl_push",  1, enc(32'h80000f00), 0, 1, 0, 0, NoCF,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0);
      add("pushF",    1, enc(32'h80000f00), 0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000f00, 0, 0, 0, 0);
      add("jr_misp",  0, 32'h0,             0, 0, 1, 1, JumpR,  32'h80000004, 1, 1, 32'h80000f00, 0, 0, 0, 0);
      add("tamp_dis", 1, 32'h80001234,      0, 0, 0, 0, NoCF,   32'h0,        1, 1, 32'h80000f00, 0, 1, 0, 0);
      add("pop_last", 0, 32'h0,             1, 0, 0, 0, NoCF,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0);

      foreach (vecs[i]) begin
         push      = vecs[i].push;
         push_data = vecs[i].pd;
         pop       = vecs[i].pop;
         flush     = vecs[i].flush;
         en_crash  = vecs[i].en;
         rb        = '0;
         rb.valid          = vecs[i].rv;
         rb.cf_type        = vecs[i].ty;
         rb.target_address = vecs[i].tgt;
         rb.is_mispredict  = (vecs[i].ty == JumpR);
         step();
         chk_outs(vecs[i].name, vecs[i].ev, vecs[i].eo, vecs[i].et, vecs[i].em, vecs[i].ec);
         if (vecs[i].ca) begin
            chk({vecs[i].name, ".addr"}, ras_addr, vecs[i].ea);
         end
      end

      // Mid-sequence reset: pending prediction and crash must both be discarded.
      idle();
      en_crash  = 1'b1;
      push      = 1'b1;
      push_data = enc(32'h80002000);
      step();
      idle();
      pop = 1'b1;
      step();
      idle();
      push      = 1'b1;
      push_data = 32'h80005555;
      step();
      chk_outs("pre_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle();
      rst_ni    = 1'b0;
      push      = 1'b1;
      push_data = enc(32'h80003000);
      step();
      chk_outs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      rst_ni            = 1'b1;
      rb.valid          = 1'b1;
      rb.cf_type        = Return;
      rb.target_address = 32'h80009999;
      step();
      chk_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      step();
      chk_outs("post_rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
